// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-step divider, h/v position counters, sync/blank
// decode aligned with the counters, and frame/game update strobes.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_DISP_START = 144,
  parameter int unsigned H_DISP_END   = 783,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_DISP_START = 35,
  parameter int unsigned V_DISP_END   = 514,
  parameter int unsigned FRAME_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic       game_tick
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned FRM_W = 6;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [FRM_W-1:0] frm_cnt, frm_nxt;
  logic             step_q;
  logic             h_sync_nxt, v_sync_nxt, bright_nxt;
  logic             at_div_end;

  // step_q marks the first clk after a pixel step, so the frame strobe
  // fires once per pixel even though the counters sit there CLK_DIV clks.
  assign at_div_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign pix_en     = en && !rst && at_div_end;
  assign frame_tick = en && step_q && (hCount == '0) &&
                      (vCount == CNT_W'(V_DISP_END + 1));
  assign game_tick  = frame_tick && (frm_cnt == FRM_W'(FRAME_DIV - 1));

  // Next-state counters and decode of the position they will hold.
  always_comb begin
    div_nxt = div_cnt;
    h_nxt   = hCount;
    v_nxt   = vCount;
    frm_nxt = frm_cnt;
    if (en) begin
      div_nxt = at_div_end ? '0 : div_cnt + DIV_W'(1);
      if (pix_en) begin
        if (hCount == CNT_W'(H_TOTAL - 1)) begin
          h_nxt = '0;
          v_nxt = (vCount == CNT_W'(V_TOTAL - 1)) ? '0 : vCount + CNT_W'(1);
        end else begin
          h_nxt = hCount + CNT_W'(1);
        end
      end
      if (frame_tick) begin
        frm_nxt = game_tick ? '0 : frm_cnt + FRM_W'(1);
      end
    end
    h_sync_nxt = (h_nxt >= CNT_W'(H_SYNC));
    v_sync_nxt = (v_nxt >= CNT_W'(V_SYNC));
    bright_nxt = (h_nxt >= CNT_W'(H_DISP_START)) && (h_nxt <= CNT_W'(H_DISP_END)) &&
                 (v_nxt >= CNT_W'(V_DISP_START)) && (v_nxt <= CNT_W'(V_DISP_END));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      hCount  <= '0;
      vCount  <= '0;
      frm_cnt <= '0;
      step_q  <= 1'b0;
      hSync   <= 1'b0;
      vSync   <= 1'b0;
      bright  <= 1'b0;
    end else if (en) begin
      div_cnt <= div_nxt;
      hCount  <= h_nxt;
      vCount  <= v_nxt;
      frm_cnt <= frm_nxt;
      step_q  <= pix_en;
      hSync   <= h_sync_nxt;
      vSync   <= v_sync_nxt;
      bright  <= bright_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance for start-up,
// enable freeze, line wrap and reset; a shrunken instance for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic       pix_a, hs_a, vs_a, br_a, ft_a, gt_a;
  logic       pix_b, hs_b, vs_b, br_b, ft_b, gt_b;
  logic [9:0] h_a, v_a, h_b, v_b;

  int n_cmp = 0;
  int n_err = 0;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_en(pix_a),
    .hCount(h_a), .vCount(v_a), .hSync(hs_a), .vSync(vs_a),
    .bright(br_a), .frame_tick(ft_a), .game_tick(gt_a)
  );

  // Small raster: 10x6 positions, 2 clks per pixel, visible h 3..7, v 2..4.
  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_DISP_START(3), .H_DISP_END(7),
    .V_TOTAL(6), .V_SYNC(1), .V_DISP_START(2), .V_DISP_END(4), .FRAME_DIV(3)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_en(pix_b),
    .hCount(h_b), .vCount(v_b), .hSync(hs_b), .vSync(vs_b),
    .bright(br_b), .frame_tick(ft_b), .game_tick(gt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic startup_a();
    rst_a = 1'b0;
    en_a  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check($sformatf("a_pix_en@%0d", k), 32'(pix_a), 32'(k % 4 == 3));
      check($sformatf("a_hcount@%0d", k), 32'(h_a), 32'(k / 4));
      check($sformatf("a_hsync@%0d", k), 32'(hs_a), 32'(0));
      check($sformatf("a_bright@%0d", k), 32'(br_a), 32'(0));
    end
  endtask

  // Hand-computed probes for the small raster: clk count after release -> state.
  int pe [14] = '{10, 20, 22, 24, 26, 44, 46, 94, 96, 100, 106, 118, 120, 121};
  int ph [14] = '{ 5,  0,  1,  2,  3,  2,  3,  7,  8,   0,   3,   9,   0,   0};
  int pv [14] = '{ 0,  1,  1,  1,  1,  2,  2,  4,  4,   5,   5,   5,   0,   0};
  int ps [14] = '{ 1,  0,  0,  1,  1,  1,  1,  1,  1,   0,   1,   1,   0,   0};
  int pw [14] = '{ 0,  1,  1,  1,  1,  1,  1,  1,  1,   1,   1,   1,   0,   0};
  int pb [14] = '{ 0,  0,  0,  0,  0,  0,  1,  1,  0,   0,   0,   0,   0,   0};

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    tick(1);
    check("a_rst_h",  32'(h_a),   32'(0));
    check("a_rst_v",  32'(v_a),   32'(0));
    check("a_rst_hs", 32'(hs_a),  32'(0));
    check("a_rst_vs", 32'(vs_a),  32'(0));
    check("a_rst_br", 32'(br_a),  32'(0));
    check("a_rst_pe", 32'(pix_a), 32'(0));
    check("a_rst_ft", 32'(ft_a),  32'(0));
    check("a_rst_gt", 32'(gt_a),  32'(0));

    startup_a();

    // Freeze at hCount=200 with the divider at 2.
    tick(790);
    check("a_pre_freeze_h", 32'(h_a), 32'(200));
    en_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("a_frz_h",  32'(h_a),   32'(200));
      check("a_frz_pe", 32'(pix_a), 32'(0));
      check("a_frz_ft", 32'(ft_a),  32'(0));
      check("a_frz_hs", 32'(hs_a),  32'(1));
    end
    en_a = 1'b1;
    tick(1);
    check("a_resume_pe", 32'(pix_a), 32'(1));
    check("a_resume_h0", 32'(h_a),   32'(200));
    tick(1);
    check("a_resume_h1", 32'(h_a),   32'(201));
    check("a_resume_pe1", 32'(pix_a), 32'(0));

    // Line wrap from (799,10), then hSync boundary on line 11.
    tick(34392);
    check("a_end_h",  32'(h_a),  32'(799));
    check("a_end_v",  32'(v_a),  32'(10));
    check("a_end_hs", 32'(hs_a), 32'(1));
    tick(4);
    check("a_wrap_h",  32'(h_a),  32'(0));
    check("a_wrap_v",  32'(v_a),  32'(11));
    check("a_wrap_hs", 32'(hs_a), 32'(0));
    tick(380);
    check("a_h95",    32'(h_a),  32'(95));
    check("a_hs95",   32'(hs_a), 32'(0));
    tick(4);
    check("a_h96",    32'(h_a),  32'(96));
    check("a_hs96",   32'(hs_a), 32'(1));
    check("a_vs11",   32'(vs_a), 32'(1));
    check("a_br11",   32'(br_a), 32'(0));

    // Asynchronous reset in the middle of a clk high phase.
    @(posedge clk);
    #3 rst_a = 1'b1;
    #1;
    check("a_arst_h",  32'(h_a),   32'(0));
    check("a_arst_v",  32'(v_a),   32'(0));
    check("a_arst_hs", 32'(hs_a),  32'(0));
    check("a_arst_vs", 32'(vs_a),  32'(0));
    check("a_arst_pe", 32'(pix_a), 32'(0));
    tick(1);
    startup_a();

    // Small raster: position/decode probes plus frame and game strobes.
    check("b_rst_h",  32'(h_b),   32'(0));
    check("b_rst_pe", 32'(pix_b), 32'(0));
    check("b_rst_ft", 32'(ft_b),  32'(0));
    rst_b = 1'b0;
    en_b  = 1'b1;
    for (int e = 1; e <= 870; e++) begin
      tick(1);
      check($sformatf("b_frame_tick@%0d", e), 32'(ft_b), 32'(e % 120 == 100));
      check($sformatf("b_game_tick@%0d", e),  32'(gt_b), 32'(e == 340 || e == 700));
      for (int i = 0; i < 14; i++) begin
        if (pe[i] == e) begin
          check($sformatf("b_h@%0d", e),      32'(h_b),  32'(ph[i]));
          check($sformatf("b_v@%0d", e),      32'(v_b),  32'(pv[i]));
          check($sformatf("b_hsync@%0d", e),  32'(hs_b), 32'(ps[i]));
          check($sformatf("b_vsync@%0d", e),  32'(vs_b), 32'(pw[i]));
          check($sformatf("b_bright@%0d", e), 32'(br_b), 32'(pb[i]));
        end
      end
    end

    // Mid-frame reset after one counted frame: game strobe must restart.
    rst_b = 1'b1;
    #1;
    check("b_arst_h",  32'(h_b),  32'(0));
    check("b_arst_v",  32'(v_b),  32'(0));
    check("b_arst_ft", 32'(ft_b), 32'(0));
    check("b_arst_gt", 32'(gt_b), 32'(0));
    tick(1);
    rst_b = 1'b0;
    for (int e = 1; e <= 360; e++) begin
      tick(1);
      check($sformatf("b2_frame_tick@%0d", e), 32'(ft_b), 32'(e % 120 == 100));
      check($sformatf("b2_game_tick@%0d", e),  32'(gt_b), 32'(e == 340));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system clocks per pixel step (100 MHz to 25 MHz).
REQ-002 SHALL have parameter H_TOTAL, default 800; H_SYNC, default 96; H_DISP_START, default 144; H_DISP_END, default 783 (inclusive).
REQ-003 SHALL have parameter V_TOTAL, default 525; V_SYNC, default 2; V_DISP_START, default 35; V_DISP_END, default 514 (inclusive).
REQ-004 SHALL have parameter FRAME_DIV, default 1: frame_tick pulses per game_tick (range 1..63).
REQ-005 SHALL have port clk  input  1  system clock, rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port en  input  1  timing advance enable; low freezes all counters.
REQ-008 SHALL have port pix_en  output  1  one-clk pixel-step strobe.
REQ-009 SHALL have port hCount  output  10  horizontal pixel position, 0..H_TOTAL-1.
REQ-010 SHALL have port vCount  output  10  vertical line position, 0..V_TOTAL-1.
REQ-011 SHALL have port hSync  output  1  horizontal sync, active-low.
REQ-012 SHALL have port vSync  output  1  vertical sync, active-low.
REQ-013 SHALL have port bright  output  1  high inside visible 640x480 area.
REQ-014 SHALL have port frame_tick  output  1  one-clk pulse at start of vertical blank.
REQ-015 SHALL have port game_tick  output  1  one-clk pulse every FRAME_DIV frames; slow update strobe for game logic.

Function
REQ-016 Divider counter div_cnt SHALL count 0..CLK_DIV-1 while en=1, wrapping to 0; pix_en=1 exactly when div_cnt==CLK_DIV-1 and en=1.
REQ-017 On a clk edge with pix_en=1, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCount SHALL increment in the same edge.
REQ-018 vCount at V_TOTAL-1 with hCount wrap SHALL wrap to 0; (H_TOTAL-1,V_TOTAL-1) -> (0,0) in one pixel step.
REQ-019 hSync, vSync, bright SHALL be registered, decoded from next-state counters, so they are valid in the same cycle as the hCount/vCount they describe (zero relative latency).
REQ-020 hSync SHALL be 0 iff hCount < H_SYNC; vSync SHALL be 0 iff vCount < V_SYNC.
REQ-021 bright SHALL be 1 iff H_DISP_START <= hCount <= H_DISP_END and V_DISP_START <= vCount <= V_DISP_END.
REQ-022 frame_tick SHALL be 1 for exactly one clk: the first clk on which counters read (0, V_DISP_END+1); not re-asserted during the remaining CLK_DIV-1 clks of that pixel.
REQ-023 Frame counter SHALL count frame_tick pulses 0..FRAME_DIV-1; game_tick SHALL coincide with frame_tick when frame counter == FRAME_DIV-1, then wrap to 0.
REQ-024 FRAME_DIV=1 SHALL make game_tick identical to frame_tick.
REQ-025 en=0 SHALL hold div_cnt, hCount, vCount, frame counter and all registered outputs; pix_en, frame_tick, game_tick SHALL be 0 while en=0.
REQ-026 Deasserting en mid-pixel and reasserting SHALL resume from held div_cnt with no skipped or duplicated pixel step.
REQ-027 Counter arithmetic SHALL be unsigned 10-bit; no count SHALL ever exceed its TOTAL-1.

Reset
REQ-028 rst=1 SHALL immediately force div_cnt=0, hCount=0, vCount=0, frame counter=0, hSync=0, vSync=0, bright=0, pix_en=0, frame_tick=0, game_tick=0.
REQ-029 rst asserted mid-frame SHALL abort the frame; no frame_tick or game_tick SHALL be emitted due to the abort.
REQ-030 After rst release with en=1, first pix_en SHALL occur on the CLK_DIV-th clk; hCount becomes 1 at that edge.

Verification
REQ-031 Release rst, en=1, defaults: pix_en high on clks 4, 8, 12; hCount 0->1->2->3; hSync=0, bright=0.
REQ-032 Run to hCount=799,vCount=10, one pixel step -> hCount=0,vCount=11; hSync low for hCount 0..95, high at 96.
REQ-033 Probe bright: (143,35)=0, (144,35)=1, (783,514)=1, (784,514)=0, (144,34)=0, (144,515)=0; vSync=0 at vCount 0..1, 1 at 2; (799,524) -> (0,0).
REQ-034 Free run defaults: frame_tick every 800*525*4=1,680,000 clks, width 1 clk, at (0,515); FRAME_DIV=3: game_tick on every 3rd frame_tick only.
REQ-035 en=0 for 7 clks at div_cnt=2, hCount=200: all values frozen, strobes 0; after en=1, pix_en after 1 clk, hCount=201.
REQ-036 Assert rst at (400,300) mid-clk: outputs zero immediately (asynchronous); release -> sequence of REQ-031 repeats, frame counter restarted.
